// File: rtl/vga_term_pkg.sv
// Shared constants, state encoding and glyph mapping for the 40x24 terminal write controller.
package vga_term_pkg;

    localparam int unsigned COLS      = 40;
    localparam int unsigned ROWS      = 24;
    localparam int unsigned RING_ROWS = 32;

    localparam logic [5:0] BLANK    = 6'd32;
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(RING_ROWS - 1);

    typedef logic [1:0] state_t;
    localparam state_t StIdle    = 2'd0;
    localparam state_t StClear   = 2'd1;
    localparam state_t StLineClr = 2'd2;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] CR_HI = 8'h8D;
    localparam logic [7:0] NUL   = 8'h00;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] DEL   = 8'h7F;
    localparam logic [7:0] ESC   = 8'h9B;

    // Bit 6 selects between the two halves of the 64-glyph ROM; bit 5 is dropped.
    function automatic logic [5:0] glyph_of(input logic [7:0] d);
        return {~d[6], d[4:0]};
    endfunction

endpackage

// File: rtl/vram_sweep.sv
// Row-major cell address generator over rows first_row..last_row, cols 0..COLS-1.
module vram_sweep
    import vga_term_pkg::*;
(
    input  logic       clk25,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] first_row,
    input  logic [4:0] last_row,
    output logic [4:0] row,
    output logic [5:0] col,
    output logic       valid,
    output logic       done
);

    logic       active_q;
    logic [4:0] row_q;
    logic [4:0] last_q;
    logic [5:0] col_q;

    assign row   = row_q;
    assign col   = col_q;
    assign valid = active_q;
    assign done  = active_q && (row_q == last_q) && (col_q == LAST_COL);

    // A new start always wins, so a running sweep restarts from its first cell.
    always_ff @(posedge clk25) begin
        if (rst) begin
            active_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            last_q   <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            row_q    <= first_row;
            col_q    <= '0;
            last_q   <= last_row;
        end else if (active_q) begin
            if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + 5'd1;
                if (row_q == last_q) begin
                    active_q <= 1'b0;
                end
            end else begin
                col_q <= col_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/vga_term_ctrl.sv
// Terminal write controller: owns the VRAM write port, tracks the cursor and scrolls a 32-row ring.
module vga_term_ctrl
    import vga_term_pkg::*;
(
    input  logic        clk25,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clr_req,
    output logic        busy,
    output logic        vram_w_en,
    output logic [10:0] vram_w_addr,
    output logic [5:0]  vram_din,
    output logic [5:0]  h_cursor,
    output logic [4:0]  v_cursor,
    output logic [4:0]  start_row
);

    state_t      state_q;
    logic [5:0]  h_q;
    logic [4:0]  v_q;
    logic [4:0]  start_q;
    logic        w_en_q;
    logic [10:0] w_addr_q;
    logic [5:0]  din_q;

    logic        accept;
    logic        is_cr;
    logic        is_nop;
    logic        is_print;
    logic        wrap;
    logic        row_adv;
    logic [4:0]  v_next;
    logic        scroll;
    logic        sweep_start;
    logic [4:0]  sweep_first;
    logic [4:0]  sweep_last;
    logic [4:0]  sweep_row;
    logic [5:0]  sweep_col;
    logic        sweep_valid;
    logic        sweep_done;

    assign char_ready = (state_q == StIdle) & ~clr_req & ~rst;
    assign busy       = (state_q != StIdle);

    assign accept   = char_valid & char_ready;
    assign is_cr    = (char_data == CR) || (char_data == CR_HI);
    assign is_nop   = (char_data == NUL) || (char_data == LF) || (char_data == DEL) ||
                      (char_data == ESC);
    assign is_print = ~is_cr & ~is_nop;
    assign wrap     = is_print && (h_q == LAST_COL);
    assign row_adv  = accept & (is_cr | wrap);
    assign v_next   = v_q + 5'd1;
    // Scroll once the new row would sit one past the bottom of the visible window.
    assign scroll   = row_adv && ((v_next - start_q) == 5'(ROWS));

    assign sweep_start = clr_req | scroll;
    assign sweep_first = clr_req ? 5'd0 : v_next;
    assign sweep_last  = clr_req ? LAST_ROW : v_next;

    vram_sweep u_sweep (
        .clk25     (clk25),
        .rst       (rst),
        .start     (sweep_start),
        .first_row (sweep_first),
        .last_row  (sweep_last),
        .row       (sweep_row),
        .col       (sweep_col),
        .valid     (sweep_valid),
        .done      (sweep_done)
    );

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q  <= StIdle;
            h_q      <= '0;
            v_q      <= '0;
            start_q  <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            din_q    <= '0;
        end else begin
            w_en_q <= 1'b0;
            if (clr_req) begin
                // The cell pending this cycle is dropped so an aborted sweep stops immediately.
                state_q <= StClear;
                h_q     <= '0;
                v_q     <= '0;
                start_q <= '0;
            end else begin
                if (sweep_valid) begin
                    w_en_q   <= 1'b1;
                    w_addr_q <= {sweep_row, sweep_col};
                    din_q    <= BLANK;
                end
                if (sweep_done) begin
                    state_q <= StIdle;
                end
                if (accept) begin
                    if (is_print) begin
                        w_en_q   <= 1'b1;
                        w_addr_q <= {v_q, h_q};
                        din_q    <= glyph_of(char_data);
                        h_q      <= wrap ? 6'd0 : h_q + 6'd1;
                    end
                    if (is_cr) begin
                        h_q <= '0;
                    end
                    if (row_adv) begin
                        v_q <= v_next;
                    end
                    if (scroll) begin
                        start_q <= start_q + 5'd1;
                        state_q <= StLineClr;
                    end
                end
            end
        end
    end

    assign vram_w_en   = w_en_q;
    assign vram_w_addr = w_addr_q;
    assign vram_din    = din_q;
    assign h_cursor    = h_q;
    assign v_cursor    = v_q;
    assign start_row   = start_q;

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Bench for vga_term_ctrl: per-cycle comparison against a write-schedule model plus directed checks.
module tb_vga_term_ctrl;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        clr_req = 1'b0;
    logic        char_ready;
    logic        busy;
    logic        vram_w_en;
    logic [10:0] vram_w_addr;
    logic [5:0]  vram_din;
    logic [5:0]  h_cursor;
    logic [4:0]  v_cursor;
    logic [4:0]  start_row;

    always #20 clk25 = ~clk25;

    vga_term_ctrl dut (
        .clk25       (clk25),
        .rst         (rst),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .clr_req     (clr_req),
        .busy        (busy),
        .vram_w_en   (vram_w_en),
        .vram_w_addr (vram_w_addr),
        .vram_din    (vram_din),
        .h_cursor    (h_cursor),
        .v_cursor    (v_cursor),
        .start_row   (start_row)
    );

    int n_chk = 0;
    int n_fail = 0;
    int wr_count = 0;
    int last_addr = 0;

    // Model: queue of writes per cycle (front = visible now, -1 = none, else addr*64+din).
    int wq[$];
    int m_h = 0, m_v = 0, m_s = 0, m_busy = 0, m_exp = -1;
    bit m_ready;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input int d);
        bit adv = 1'b0;
        bit wrote = 1'b0;
        if (d == 13 || d == 141) begin
            m_h = 0;
            adv = 1'b1;
        end else if (d == 0 || d == 10 || d == 127 || d == 155) begin
            adv = 1'b0;
        end else begin
            wq.push_back((m_v * 64 + m_h) * 64 + (((d & 64) != 0) ? 0 : 32) + d % 32);
            wrote = 1'b1;
            if (m_h == 39) begin
                m_h = 0;
                adv = 1'b1;
            end else begin
                m_h++;
            end
        end
        if (adv) begin
            m_v = (m_v + 1) % 32;
            if ((m_v - m_s + 32) % 32 == 24) begin
                m_s = (m_s + 1) % 32;
                if (!wrote) wq.push_back(-1);
                for (int c = 0; c < 40; c++) wq.push_back((m_v * 64 + c) * 64 + 32);
                m_busy = 40;
            end
        end
    endtask

    always @(posedge clk25) begin
        m_ready = (m_busy == 0) && !clr_req && !rst;
        if (wq.size() > 0) void'(wq.pop_front());
        if (m_busy > 0) m_busy--;
        if (rst) begin
            wq.delete();
            m_busy = 0; m_h = 0; m_v = 0; m_s = 0;
        end else if (clr_req) begin
            wq.delete();
            wq.push_back(-1);
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 40; c++) wq.push_back((r * 64 + c) * 64 + 32);
            m_busy = 1280; m_h = 0; m_v = 0; m_s = 0;
        end else if (char_valid && m_ready) begin
            model_accept(int'(char_data));
        end
        #1;
        m_exp = (wq.size() > 0) ? wq[0] : -1;
        check("w_en", int'(vram_w_en), int'(m_exp >= 0));
        if (m_exp >= 0) begin
            check("w_addr", int'(vram_w_addr), m_exp / 64);
            check("din", int'(vram_din), m_exp % 64);
        end
        check("h_cursor", int'(h_cursor), m_h);
        check("v_cursor", int'(v_cursor), m_v);
        check("start_row", int'(start_row), m_s);
        check("busy", int'(busy), int'(m_busy > 0));
        check("char_ready", int'(char_ready), int'((m_busy == 0) && !clr_req && !rst));
        if (vram_w_en) begin
            wr_count++;
            last_addr = int'(vram_w_addr);
        end
    end

    // Offer a byte and return once it is accepted; valid stays high for back-to-back sends.
    task automatic send(input logic [7:0] d, output int waited);
        waited = 0;
        @(negedge clk25);
        char_valid = 1'b1;
        char_data  = d;
        while (!char_ready && waited < 3000) begin
            @(negedge clk25);
            waited++;
        end
        if (waited >= 3000) check("handshake_timeout", 1, 0);
        @(posedge clk25);
        #2;
    endtask

    task automatic pulse_clr();
        @(negedge clk25);
        char_valid = 1'b0;
        clr_req    = 1'b1;
        @(negedge clk25);
        clr_req = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 3000) begin
            @(negedge clk25);
            cycles++;
        end
        if (cycles >= 3000) check("idle_timeout", 1, 0);
    endtask

    int w, n;
    logic [7:0] nops [4];

    initial begin
        nops[0] = 8'h0A; nops[1] = 8'h7F; nops[2] = 8'h9B; nops[3] = 8'h00;
        repeat (2) @(negedge clk25);
        rst = 1'b0;
        check("rst_w_en", int'(vram_w_en), 0);
        check("rst_h", int'(h_cursor), 0);
        check("rst_busy", int'(busy), 0);

        // Full clear: 1280 writes, busy for 1280 cycles.
        wr_count = 0;
        pulse_clr();
        wait_idle(n);
        check("clear_busy_cycles", n, 1280);
        check("clear_writes", wr_count, 1280);
        check("clear_last_addr", last_addr, 31 * 64 + 39);
        check("clear_ready", int'(char_ready), 1);

        send(8'hC1, w);
        check("c1_addr", int'(vram_w_addr), 0);
        check("c1_din", int'(vram_din), 1);
        check("c1_h", int'(h_cursor), 1);

        for (int i = 0; i < 39; i++) send(8'h41 + 8'(i), w);
        check("wrap_addr", int'(vram_w_addr), 39);
        check("wrap_din", int'(vram_din), 7);
        check("wrap_h", int'(h_cursor), 0);
        check("wrap_v", int'(v_cursor), 1);

        // Scroll after 24 CRs from the top.
        pulse_clr();
        wait_idle(n);
        wr_count = 0;
        for (int i = 0; i < 24; i++) send(8'h0D, w);
        check("scroll_start", int'(start_row), 1);
        check("scroll_v", int'(v_cursor), 24);
        @(negedge clk25);
        char_valid = 1'b0;
        n = 0;
        while (!char_ready && n < 100) begin
            n++;
            @(negedge clk25);
        end
        check("scroll_ready_low", n, 40);
        check("scroll_writes", wr_count, 40);
        check("scroll_last_addr", last_addr, 24 * 64 + 39);

        // Consumed control codes: one cycle each, no write, cursor unchanged.
        for (int i = 0; i < 4; i++) begin
            send(nops[i], w);
            check("nop_wait", w, 0);
            check("nop_w_en", int'(vram_w_en), 0);
            check("nop_v", int'(v_cursor), 24);
        end

        // Abort a line clear at its 17th write.
        wr_count = 0;
        send(8'h8D, w);
        check("abort_scroll_start", int'(start_row), 2);
        n = 0;
        while (wr_count < 17 && n < 100) begin
            @(negedge clk25);
            n++;
        end
        char_valid = 1'b0;
        clr_req = 1'b1;
        @(posedge clk25);
        #2;
        check("abort_v", int'(v_cursor), 0);
        check("abort_start", int'(start_row), 0);
        check("abort_no_write", int'(vram_w_en), 0);
        @(negedge clk25);
        clr_req = 1'b0;
        @(posedge clk25);
        #2;
        check("abort_first_addr", int'(vram_w_addr), 0);
        check("abort_first_din", int'(vram_din), 32);
        wait_idle(n);

        // Character offered together with a clear request is not taken.
        send(8'h42, w);
        @(negedge clk25);
        char_data = 8'h43;
        clr_req = 1'b1;
        #1;
        check("clr_blocks_ready", int'(char_ready), 0);
        @(posedge clk25);
        #2;
        check("clr_char_h", int'(h_cursor), 0);
        @(negedge clk25);
        clr_req = 1'b0;
        char_valid = 1'b0;
        wait_idle(n);

        // Reset mid-clear stops the sweep.
        pulse_clr();
        repeat (50) @(negedge clk25);
        rst = 1'b1;
        @(negedge clk25);
        rst = 1'b0;
        wr_count = 0;
        repeat (20) @(negedge clk25);
        check("rst_abort_writes", wr_count, 0);
        check("rst_abort_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
